// File: rtl/fire_actuator_sequencer_if.sv
// Signal bundle between the CPU-side controller and the fire actuator sequencer.
// Signal names match the legacy flat port list so existing connections map one-to-one.
interface fire_actuator_sequencer_if;
    logic       enable_fire_pulse_in;
    logic       cpu_lock_in;
    logic       cpu_flush_in;
    logic       manual_lock_in;
    logic       actuator_ack_in;
    logic       rearm_in;
    logic       fault_clear_in;
    logic       fire_req;
    logic       busy;
    logic       fault;
    logic       dropped_pulse;
    logic [7:0] shot_count;
    logic [7:0] shots_remaining;
    logic [1:0] state_debug;

    modport master (
        output enable_fire_pulse_in,
        output cpu_lock_in,
        output cpu_flush_in,
        output manual_lock_in,
        output actuator_ack_in,
        output rearm_in,
        output fault_clear_in,
        input  fire_req,
        input  busy,
        input  fault,
        input  dropped_pulse,
        input  shot_count,
        input  shots_remaining,
        input  state_debug
    );

    modport slave (
        input  enable_fire_pulse_in,
        input  cpu_lock_in,
        input  cpu_flush_in,
        input  manual_lock_in,
        input  actuator_ack_in,
        input  rearm_in,
        input  fault_clear_in,
        output fire_req,
        output busy,
        output fault,
        output dropped_pulse,
        output shot_count,
        output shots_remaining,
        output state_debug
    );
endinterface

// File: rtl/fire_actuator_sequencer.sv
// Sequences a single actuator shot per authorized fire pulse: request, ack/abort/timeout,
// cooldown, with a reloadable shot budget and a sticky fault on ack timeout.
module fire_actuator_sequencer #(
    parameter int unsigned COOLDOWN_CYCLES = 16,
    parameter int unsigned ACK_TIMEOUT     = 8,
    parameter int unsigned MAX_SHOTS       = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    fire_actuator_sequencer_if.slave   io
);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_FIRE     = 2'd1;
    localparam logic [1:0] ST_COOLDOWN = 2'd2;
    localparam logic [1:0] ST_FAULT    = 2'd3;

    localparam logic [7:0] COOLDOWN_LAST = 8'(COOLDOWN_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST  = 8'(ACK_TIMEOUT - 1);
    localparam logic [7:0] SHOT_BUDGET   = 8'(MAX_SHOTS);

    logic [1:0] state,      state_nxt;
    logic [7:0] timer,      timer_nxt;
    logic [7:0] shot_count, shot_count_nxt;
    logic [7:0] remaining,  remaining_nxt;
    logic       fire_req;
    logic       dropped;
    logic       accept;
    logic       ack_taken;

    assign accept = io.enable_fire_pulse_in && (state == ST_IDLE) && !io.cpu_lock_in
                    && !io.manual_lock_in && (remaining != 8'd0);

    // One timer serves both states: counts up in FIRE (ack timeout), down in COOLDOWN.
    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        ack_taken = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_FIRE;
                    timer_nxt = '0;
                end
            end
            ST_FIRE: begin
                if (io.actuator_ack_in) begin
                    state_nxt = ST_COOLDOWN;
                    timer_nxt = COOLDOWN_LAST;
                    ack_taken = 1'b1;
                end else if (io.cpu_flush_in || io.manual_lock_in) begin
                    state_nxt = ST_COOLDOWN;
                    timer_nxt = COOLDOWN_LAST;
                end else if (timer == TIMEOUT_LAST) begin
                    state_nxt = ST_FAULT;
                    timer_nxt = '0;
                end else begin
                    timer_nxt = timer + 8'd1;
                end
            end
            ST_COOLDOWN: begin
                if (timer == 8'd0) begin
                    state_nxt = ST_IDLE;
                end else begin
                    timer_nxt = timer - 8'd1;
                end
            end
            ST_FAULT: begin
                if (io.fault_clear_in) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                timer_nxt = '0;
            end
        endcase
    end

    // Rearm wins over a same-cycle ack decrement; the shot itself is still counted.
    always_comb begin
        shot_count_nxt = shot_count;
        remaining_nxt  = remaining;
        if (ack_taken && (shot_count != 8'hFF)) begin
            shot_count_nxt = shot_count + 8'd1;
        end
        if (io.rearm_in) begin
            remaining_nxt = SHOT_BUDGET;
        end else if (ack_taken && (remaining != 8'd0)) begin
            remaining_nxt = remaining - 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            timer      <= '0;
            shot_count <= '0;
            remaining  <= SHOT_BUDGET;
            fire_req   <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            state      <= state_nxt;
            timer      <= timer_nxt;
            shot_count <= shot_count_nxt;
            remaining  <= remaining_nxt;
            fire_req   <= (state_nxt == ST_FIRE);
            dropped    <= io.enable_fire_pulse_in && !accept;
        end
    end

    assign io.fire_req        = fire_req;
    assign io.busy            = (state != ST_IDLE);
    assign io.fault           = (state == ST_FAULT);
    assign io.dropped_pulse   = dropped;
    assign io.shot_count      = shot_count;
    assign io.shots_remaining = remaining;
    assign io.state_debug     = state;

endmodule

// File: doc/fire_actuator_sequencer.md
FIRE_ACTUATOR_SEQUENCER -- requirements
Module: fire_actuator_sequencer

Parameters
REQ-001 The block SHALL have parameter COOLDOWN_CYCLES, default 16: cycles spent in COOLDOWN after each completed or aborted shot (legal 1..255).
REQ-002 The block SHALL have parameter ACK_TIMEOUT, default 8: maximum cycles fire_req may stay high without actuator_ack_in (legal 1..255).
REQ-003 The block SHALL have parameter MAX_SHOTS, default 4: shot budget loaded at reset and on rearm_in (legal 1..255).

Interface
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port enable_fire_pulse_in, input, 1 bit: 1-cycle fire authorization pulse from the CPU pipeline's system_enable_fire_pulse.
REQ-007 The block SHALL have port cpu_lock_in, input, 1 bit: pipeline lock status; blocks new shots.
REQ-008 The block SHALL have port cpu_flush_in, input, 1 bit: pipeline flush; aborts a pending shot.
REQ-009 The block SHALL have port manual_lock_in, input, 1 bit: manual safety; blocks new shots and aborts a pending shot.
REQ-010 The block SHALL have port actuator_ack_in, input, 1 bit: actuator confirms the shot.
REQ-011 The block SHALL have port rearm_in, input, 1 bit: reloads the shot budget.
REQ-012 The block SHALL have port fault_clear_in, input, 1 bit: releases FAULT.
REQ-013 The block SHALL have port fire_req, output, 1 bit: actuator request, registered.
REQ-014 The block SHALL have port busy, output, 1 bit: high when state is not IDLE.
REQ-015 The block SHALL have port fault, output, 1 bit: high in FAULT.
REQ-016 The block SHALL have port dropped_pulse, output, 1 bit: 1-cycle flag that a fire pulse was rejected.
REQ-017 The block SHALL have port shot_count, output, 8 bits: acknowledged shots since reset, saturating at 255.
REQ-018 The block SHALL have port shots_remaining, output, 8 bits: remaining budget.
REQ-019 The block SHALL have port state_debug, output, 2 bits: IDLE=0, FIRE=1, COOLDOWN=2, FAULT=3.

Function
REQ-020 In IDLE, the block SHALL accept an enable_fire_pulse_in sampled high when cpu_lock_in=0, manual_lock_in=0 and shots_remaining>0. On the next edge it enters FIRE, sets fire_req=1 and clears the timeout timer.
REQ-021 The block SHALL reject any pulse not accepted per REQ-020, including pulses in FIRE, COOLDOWN or FAULT. On the next cycle dropped_pulse is 1 for exactly one cycle and the state is unchanged.
REQ-022 In FIRE, when actuator_ack_in=1 the block SHALL, on the next edge:
 - enter COOLDOWN and drive fire_req=0;
 - increment shot_count (saturating);
 - decrement shots_remaining.
REQ-023 In FIRE without ack, when cpu_flush_in=1 or manual_lock_in=1 the block SHALL, on the next edge, enter COOLDOWN with fire_req=0 and leave both counters unchanged (abort).
REQ-024 In FIRE, when fire_req has been high ACK_TIMEOUT cycles with no ack and no abort, the block SHALL enter FAULT on the next edge with fire_req=0 and fault=1.
REQ-025 FIRE priority SHALL be ack > abort > timeout when these coincide in one cycle.
REQ-026 COOLDOWN SHALL last exactly COOLDOWN_CYCLES cycles, then return to IDLE.
REQ-027 FAULT SHALL hold until fault_clear_in=1, then go to IDLE on the next edge. fire_req stays 0 throughout.
REQ-028 rearm_in=1 SHALL load shots_remaining=MAX_SHOTS on the next edge in any state. It overrides a same-cycle ack decrement; shot_count still increments.
REQ-029 In IDLE, the block SHALL treat shots_remaining=0 as a rejection condition only; no state change occurs.

Reset
REQ-030 reset=1 SHALL take priority over all inputs. On the next edge it forces:
 - state=IDLE;
 - fire_req=0, busy=0, fault=0, dropped_pulse=0;
 - shot_count=0 and shots_remaining=MAX_SHOTS;
 - timers cleared.
 This applies mid-FIRE, mid-COOLDOWN and in FAULT.

Verification
REQ-031 Pulse at cycle N in IDLE, ack at N+3 -> fire_req high N+1..N+3; COOLDOWN N+4..N+19; IDLE at N+20; shot_count=1; shots_remaining=3.
REQ-032 Pulse with no ack -> fire_req high 8 cycles; FAULT with fault=1 one cycle later; a pulse in FAULT gives dropped_pulse=1; fault_clear_in gives IDLE.
REQ-033 Five accepted-condition pulses, each acked, no rearm -> fifth pulse gives dropped_pulse=1 with shots_remaining=0; rearm_in then restores 4 and the next pulse fires.
REQ-034 cpu_flush_in and actuator_ack_in in the same FIRE cycle -> counted shot (shot_count+1); manual_lock_in alone in FIRE -> abort with counters unchanged.
REQ-035 Pulse with cpu_lock_in=1 -> dropped_pulse=1, fire_req stays 0; a pulse during COOLDOWN is dropped.
REQ-036 reset asserted mid-FIRE and mid-FAULT -> all outputs at reset values on the next edge; shots_remaining=4.
